pc_unit: RTL

- Parametrised next-generation program counter for the multi-cycle CPU.
- Holds the PC, selects the next PC from the same sources as the current PC logic (ALU result, branch target, jump), and adds:
  - bne as well as beq branching,
  - a stall input,
  - exception redirect with EPC capture,
  - a circular return-address stack (RAS) for call/return.
- Sits between the control FSM/ALU and instruction memory address.

---
 rtl/pc_unit.sv | 125 ++++++++++++
 1 files changed

// File: rtl/pc_unit.sv
// Program counter with beq/bne branching, stall, exception redirect with EPC
// capture, and a circular return-address stack for call/return.
module pc_unit #(
  parameter int unsigned      WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter logic [31:0]      TRAP_VECTOR  = 32'h0000_0180,
  parameter int unsigned      RAS_DEPTH    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             PCWrite,
  input  logic             PCWriteCond,
  input  logic             BranchNE,
  input  logic [1:0]       PCSource,
  input  logic             zero,
  input  logic [WIDTH-1:0] result,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [25:0]      IR_low26,
  input  logic             stall,
  input  logic             exception,
  input  logic             ras_push,
  output logic [WIDTH-1:0] PCvalue,
  output logic [WIDTH-1:0] EPC,
  output logic             ras_empty,
  output logic             ras_full,
  output logic             ras_underflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [WIDTH-1:0] TRAP_PC = WIDTH'(TRAP_VECTOR);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_epc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;
  logic [CNT_W-1:0] r_count;
  logic             r_underflow;

  logic             w_taken;
  logic             w_sel;
  logic             w_pop;
  logic             w_push;
  logic             w_empty;
  logic             w_full;
  logic             w_pop_ok;
  logic [PTR_W-1:0] w_top_inc;
  logic [PTR_W-1:0] w_wr_idx;
  logic [WIDTH-1:0] w_jump;
  logic [WIDTH-1:0] w_next_pc;

  if (WIDTH > 28) begin : g_jump_hi
    assign w_jump = {r_pc[WIDTH-1:28], IR_low26, 2'b00};
  end else begin : g_jump_lo
    assign w_jump = {IR_low26, 2'b00};
  end

  assign w_taken   = PCWriteCond && (zero != BranchNE);
  assign w_sel     = !exception && !stall && !w_taken && PCWrite;
  assign w_pop     = w_sel && (PCSource == 2'b11);
  assign w_push    = w_sel && ras_push;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(RAS_DEPTH));
  assign w_pop_ok  = w_pop && !w_empty;
  assign w_top_inc = r_top + PTR_W'(1);
  // Push with a successful pop reuses the popped slot instead of advancing.
  assign w_wr_idx  = w_pop_ok ? r_top : w_top_inc;

  always_comb begin
    w_next_pc = r_pc;
    if (exception) begin
      w_next_pc = TRAP_PC;
    end else if (stall) begin
      w_next_pc = r_pc;
    end else if (w_taken) begin
      w_next_pc = ALUOut;
    end else if (PCWrite) begin
      unique case (PCSource)
        2'b00:   w_next_pc = result;
        2'b01:   w_next_pc = ALUOut;
        2'b10:   w_next_pc = w_jump;
        default: w_next_pc = w_empty ? r_pc : r_ras[r_top];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc        <= RESET_VECTOR;
      r_epc       <= '0;
      r_top       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else begin
      r_pc        <= w_next_pc;
      r_underflow <= w_pop && w_empty;
      if (exception) begin
        r_epc <= r_pc;
      end
      if (w_pop_ok && !w_push) begin
        r_top   <= r_top - PTR_W'(1);
        r_count <= r_count - CNT_W'(1);
      end else if (w_push && !w_pop_ok) begin
        r_top <= w_top_inc;
        if (!w_full) begin
          r_count <= r_count + CNT_W'(1);
        end
      end
    end
  end

  // Entry contents are don't-care after reset; a full push overwrites the oldest.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_ras[w_wr_idx] <= r_pc;
    end
  end

  assign PCvalue       = r_pc;
  assign EPC           = r_epc;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;
  assign ras_underflow = r_underflow;

endmodule
